packet_read_arbiter: RTL and testbench
======================================

// Module: packet_read_arbiter
// PURPOSE
//  Round-robin read scheduler for pNUM_PORTS packet buffers (reg_file data + length fifo per port).
//  Picks one buffer holding a complete packet, pops its length word and streams exactly that many
//  bytes to the shared TX byte interface, with SOF/EOF markers and an inter-frame gap.
//  Sits between the per-port packet buffers and the single MAC TX path.
// PARAMETERS
//  pNUM_PORTS         4     number of packet buffers arbitrated (>=2)
//  pDATA_WIDTH        8     byte lane width
//  pMIN_PACKET_LENGHT 64    shortest legal frame, bytes
//  pMAX_PACKET_LENGHT 1536  longest legal frame, bytes
//  pFIFO_WIDTH        $clog2(pMAX_PACKET_LENGHT)  width of one length word
//  pIFG_CYCLES        12    idle cycles forced between frames (>=1)
// PORTS
//  iclk        in   1                         clock
//  i_rst       in   1                         synchronous reset, active-high
//  i_pkt_ready in   pNUM_PORTS                bit n = length fifo n not empty
//  i_pkt_len   in   pNUM_PORTS*pFIFO_WIDTH    fifo n head length word, slice n
//  i_rd_data   in   pNUM_PORTS*pDATA_WIDTH    byte at read pointer of buffer n (combinational read)
//  i_tx_ready  in   1                         downstream accepts a byte this cycle
//  o_len_pop   out  pNUM_PORTS                one-hot 1-cycle pop of length fifo n
//  o_rd_en     out  pNUM_PORTS                one-hot: advance read pointer of buffer n
//  o_tx_d      out  pDATA_WIDTH               TX byte
//  o_tx_en     out  1                         o_tx_d valid
//  o_tx_sof    out  1                         first byte of frame (with o_tx_en)
//  o_tx_eof    out  1                         last byte of frame (with o_tx_en)
//  o_len_err   out  1                         1-cycle pulse: popped length illegal, frame dropped
//  o_grant     out  $clog2(pNUM_PORTS)        index of port currently granted
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, round-robin pointer=0, byte counter=0, gap counter=0.
//  FSM IDLE -> POP -> STREAM|DRAIN -> GAP -> IDLE.
//  IDLE: if any i_pkt_ready, grant first set bit at/after rr pointer (wrap at pNUM_PORTS);
//   latch o_grant; go POP. None ready -> stay.
//  POP (1 cycle): o_len_pop[grant]=1; latch len=i_pkt_len slice; rr pointer <= grant+1 mod N.
//   len in [pMIN,pMAX] -> STREAM; len==0 -> GAP with o_len_err; other -> DRAIN with o_len_err.
//  STREAM: each cycle with i_tx_ready=1 and remaining>0: o_rd_en[grant]=1, register
//   i_rd_data slice to o_tx_d, o_tx_en=1 next cycle (1-cycle latency rd_en -> o_tx_en).
//   o_tx_sof on byte 1, o_tx_eof on byte len. i_tx_ready=0: no rd_en, o_tx_en=0 next cycle,
//   o_tx_d holds, counter holds. Last byte issued -> GAP.
//  DRAIN: o_rd_en[grant]=1 every cycle for len bytes (keeps pointer aligned), o_tx_en=0, then GAP.
//   DRAIN ignores i_tx_ready.
//  GAP: pIFG_CYCLES cycles, all o_rd_en/o_tx_en 0, then IDLE; no new grant while in GAP.
//  Counters pFIFO_WIDTH+1 bits; remaining decrements only on issued byte; never underflows.
//  Grant fixed for the whole frame; i_pkt_ready changes mid-frame ignored.
//  Simultaneous requests: strict round-robin, no port served twice while another waits.
//  i_rst mid-frame: frame truncated, no EOF, outputs 0 next cycle; buffers reset alongside.
//  o_rd_en and o_len_pop are never asserted for a port other than o_grant.
// STRUCTURE
//  Shared package: FSM state encodings (lpIDLE, lpPOP, lpSTREAM, lpDRAIN, lpGAP), pIFG default.
//  Sub-module rr_pick: combinational round-robin priority encoder (req, pointer -> index, valid).
//  Top: FSM, counters, per-port slice mux, output registers.
// TESTING
//  Port 1 only, len=64, i_tx_ready=1 -> one pop; 64 rd_en; SOF byte1, EOF byte64; 12 idle cycles.
//  Ports 0..3 ready, len=64 each -> grant order 0,1,2,3; next request on port 0 served after 3.
//  len=100, i_tx_ready low cycles 10-14 -> 100 bytes, no dup/skip, tx_en gaps match stalls.
//  len=20 on port 2 -> o_len_err pulse, 20 rd_en with tx_en=0, then port 3 served normally.
//  len=0 popped -> o_len_err, no rd_en, GAP then IDLE; len=1536 -> 1536 bytes, counter no wrap.
//  i_rst asserted at byte 30 of a frame -> all outputs 0 next cycle, rr pointer 0, FSM IDLE.

Source files
------------

// File: rtl/packet_read_arbiter_pkg.sv
// Shared definitions for the packet read arbiter: FSM encoding, defaults and a length helper.
package packet_read_arbiter_pkg;

    typedef enum logic [2:0] {
        lpIDLE   = 3'd0,
        lpPOP    = 3'd1,
        lpSTREAM = 3'd2,
        lpDRAIN  = 3'd3,
        lpGAP    = 3'd4
    } arb_state_t;

    localparam int lpIFG_DEFAULT = 12;

    // True when a popped length describes a frame that may be sent on the wire.
    function automatic logic len_in_range(
        input int unsigned len_v,
        input int unsigned min_v,
        input int unsigned max_v
    );
        return (len_v >= min_v) && (len_v <= max_v);
    endfunction

endpackage

// File: rtl/packet_read_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first request at or after the pointer, wrapping.
module packet_read_arbiter_rr_pick #(
    parameter int pNUM_PORTS = 4,
    parameter int pIDX_W     = 2
) (
    input  logic [pNUM_PORTS-1:0] i_req,
    input  logic [pIDX_W-1:0]     i_ptr,
    output logic [pIDX_W-1:0]     o_idx,
    output logic                  o_valid
);

    // Scan from the farthest offset back toward the pointer so the nearest requester wins.
    always_comb begin
        int w_pos;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int k = pNUM_PORTS - 1; k >= 0; k--) begin
            w_pos   = (int'(i_ptr) + k) % pNUM_PORTS;
            o_idx   = i_req[w_pos] ? pIDX_W'(w_pos) : o_idx;
            o_valid = o_valid | i_req[w_pos];
        end
    end

endmodule

// File: rtl/packet_read_arbiter.sv
// Round-robin read scheduler: grants one packet buffer at a time, pops its length word and
// streams that many bytes to the shared TX byte interface, followed by an inter-frame gap.
// Illegal lengths are drained from the buffer (pointer kept aligned) without transmitting.
module packet_read_arbiter
    import packet_read_arbiter_pkg::*;
#(
    parameter int pNUM_PORTS         = 4,
    parameter int pDATA_WIDTH        = 8,
    parameter int pMIN_PACKET_LENGHT = 64,
    parameter int pMAX_PACKET_LENGHT = 1536,
    parameter int pFIFO_WIDTH        = $clog2(pMAX_PACKET_LENGHT),
    parameter int pIFG_CYCLES        = lpIFG_DEFAULT
) (
    input  logic                              iclk,
    input  logic                              i_rst,
    input  logic [pNUM_PORTS-1:0]             i_pkt_ready,
    input  logic [pNUM_PORTS*pFIFO_WIDTH-1:0] i_pkt_len,
    input  logic [pNUM_PORTS*pDATA_WIDTH-1:0] i_rd_data,
    input  logic                              i_tx_ready,
    output logic [pNUM_PORTS-1:0]             o_len_pop,
    output logic [pNUM_PORTS-1:0]             o_rd_en,
    output logic [pDATA_WIDTH-1:0]            o_tx_d,
    output logic                              o_tx_en,
    output logic                              o_tx_sof,
    output logic                              o_tx_eof,
    output logic                              o_len_err,
    output logic [$clog2(pNUM_PORTS)-1:0]     o_grant
);

    localparam int lpIDX_W = $clog2(pNUM_PORTS);
    localparam int lpCNT_W = pFIFO_WIDTH + 1;
    localparam int lpGAP_W = $clog2(pIFG_CYCLES + 1);

    arb_state_t                r_state;
    arb_state_t                w_next_state;
    logic [lpIDX_W-1:0]        r_grant;
    logic [lpIDX_W-1:0]        r_rr_ptr;
    logic [lpCNT_W-1:0]        r_len;
    logic [lpCNT_W-1:0]        r_remain;
    logic [lpGAP_W-1:0]        r_gap_cnt;
    logic [pNUM_PORTS-1:0]     r_len_pop;
    logic                      r_len_err;
    logic [pDATA_WIDTH-1:0]    r_tx_d;
    logic                      r_tx_en;
    logic                      r_tx_sof;
    logic                      r_tx_eof;

    logic [lpIDX_W-1:0]        w_pick_idx;
    logic                      w_pick_valid;
    logic [pNUM_PORTS-1:0]     w_pick_oh;
    logic [pNUM_PORTS-1:0]     w_grant_oh;
    logic [pFIFO_WIDTH-1:0]    w_len_sel;
    logic [pDATA_WIDTH-1:0]    w_data_sel;
    logic                      w_len_legal;
    logic                      w_len_zero;
    logic                      w_issue;
    logic                      w_drain_rd;

    packet_read_arbiter_rr_pick #(
        .pNUM_PORTS (pNUM_PORTS),
        .pIDX_W     (lpIDX_W)
    ) u_rr_pick (
        .i_req   (i_pkt_ready),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Per-port slice selection always follows the registered grant.
    assign w_len_sel   = i_pkt_len[int'(r_grant)*pFIFO_WIDTH +: pFIFO_WIDTH];
    assign w_data_sel  = i_rd_data[int'(r_grant)*pDATA_WIDTH +: pDATA_WIDTH];
    assign w_pick_oh   = pNUM_PORTS'(1) << w_pick_idx;
    assign w_grant_oh  = pNUM_PORTS'(1) << r_grant;
    assign w_len_legal = len_in_range(32'(w_len_sel), pMIN_PACKET_LENGHT, pMAX_PACKET_LENGHT);
    assign w_len_zero  = (w_len_sel == '0);

    // Next-state decode plus the per-cycle read strobes for streaming and draining.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_drain_rd   = 1'b0;
        case (r_state)
            lpIDLE: begin
                if (w_pick_valid) begin
                    w_next_state = lpPOP;
                end else begin
                    w_next_state = lpIDLE;
                end
            end
            lpPOP: begin
                if (w_len_legal) begin
                    w_next_state = lpSTREAM;
                end else if (w_len_zero) begin
                    w_next_state = lpGAP;
                end else begin
                    w_next_state = lpDRAIN;
                end
            end
            lpSTREAM: begin
                if (r_remain == '0) begin
                    w_next_state = lpGAP;
                end else if (i_tx_ready) begin
                    w_issue      = 1'b1;
                    w_next_state = (r_remain == lpCNT_W'(1)) ? lpGAP : lpSTREAM;
                end else begin
                    w_next_state = lpSTREAM;
                end
            end
            lpDRAIN: begin
                if (r_remain == '0) begin
                    w_next_state = lpGAP;
                end else begin
                    w_drain_rd   = 1'b1;
                    w_next_state = (r_remain == lpCNT_W'(1)) ? lpGAP : lpDRAIN;
                end
            end
            lpGAP: begin
                if (r_gap_cnt == lpGAP_W'(pIFG_CYCLES - 1)) begin
                    w_next_state = lpIDLE;
                end else begin
                    w_next_state = lpGAP;
                end
            end
            default: begin
                w_next_state = lpIDLE;
            end
        endcase
    end

    // State register, grant/round-robin pointer, length and gap counters, pop/error pulses.
    always_ff @(posedge iclk) begin
        if (i_rst) begin
            r_state   <= lpIDLE;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_len     <= '0;
            r_remain  <= '0;
            r_gap_cnt <= '0;
            r_len_pop <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_len_pop <= '0;
            r_len_err <= 1'b0;
            case (r_state)
                lpIDLE: begin
                    r_gap_cnt <= '0;
                    if (w_pick_valid) begin
                        r_grant   <= w_pick_idx;
                        r_len_pop <= w_pick_oh;
                    end
                end
                lpPOP: begin
                    r_len     <= {1'b0, w_len_sel};
                    r_remain  <= {1'b0, w_len_sel};
                    r_rr_ptr  <= (r_grant == lpIDX_W'(pNUM_PORTS - 1)) ? '0 : r_grant + lpIDX_W'(1);
                    r_len_err <= ~w_len_legal;
                end
                lpSTREAM, lpDRAIN: begin
                    if (w_issue | w_drain_rd) begin
                        r_remain <= r_remain - lpCNT_W'(1);
                    end
                end
                lpGAP: begin
                    r_gap_cnt <= r_gap_cnt + lpGAP_W'(1);
                end
                default: begin
                    r_gap_cnt <= '0;
                end
            endcase
        end
    end

    // TX output register: one cycle behind the read strobe; data holds across stalls.
    always_ff @(posedge iclk) begin
        if (i_rst) begin
            r_tx_d   <= '0;
            r_tx_en  <= 1'b0;
            r_tx_sof <= 1'b0;
            r_tx_eof <= 1'b0;
        end else if (w_issue) begin
            r_tx_d   <= w_data_sel;
            r_tx_en  <= 1'b1;
            r_tx_sof <= (r_remain == r_len);
            r_tx_eof <= (r_remain == lpCNT_W'(1));
        end else begin
            r_tx_en  <= 1'b0;
            r_tx_sof <= 1'b0;
            r_tx_eof <= 1'b0;
        end
    end

    assign o_len_pop = r_len_pop;
    assign o_rd_en   = (w_issue | w_drain_rd) ? w_grant_oh : '0;
    assign o_tx_d    = r_tx_d;
    assign o_tx_en   = r_tx_en;
    assign o_tx_sof  = r_tx_sof;
    assign o_tx_eof  = r_tx_eof;
    assign o_len_err = r_len_err;
    assign o_grant   = r_grant;

endmodule

// File: tb/tb_packet_read_arbiter.sv
// Self-checking bench for packet_read_arbiter. The bench owns the packet buffers (length
// queues and byte memories), predicts grant order, frame contents and error pulses from the
// arbitration rules, and compares every cycle at the falling clock edge.
module tb_packet_read_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int FW   = 11;
    localparam int IFG  = 12;
    localparam int MINL = 64;
    localparam int MAXL = 1536;
    localparam logic [11:0] NONE = 12'hFFF;
    localparam int NV   = 7;

    logic              iclk = 1'b0;
    logic              i_rst;
    logic [N-1:0]      i_pkt_ready;
    logic [N*FW-1:0]   i_pkt_len;
    logic [N*DW-1:0]   i_rd_data;
    logic              i_tx_ready;
    logic [N-1:0]      o_len_pop;
    logic [N-1:0]      o_rd_en;
    logic [DW-1:0]     o_tx_d;
    logic              o_tx_en;
    logic              o_tx_sof;
    logic              o_tx_eof;
    logic              o_len_err;
    logic [1:0]        o_grant;

    always #5 iclk = ~iclk;

    packet_read_arbiter #(
        .pNUM_PORTS(N), .pDATA_WIDTH(DW), .pMIN_PACKET_LENGHT(MINL),
        .pMAX_PACKET_LENGHT(MAXL), .pFIFO_WIDTH(FW), .pIFG_CYCLES(IFG)
    ) dut (
        .iclk(iclk), .i_rst(i_rst), .i_pkt_ready(i_pkt_ready), .i_pkt_len(i_pkt_len),
        .i_rd_data(i_rd_data), .i_tx_ready(i_tx_ready), .o_len_pop(o_len_pop),
        .o_rd_en(o_rd_en), .o_tx_d(o_tx_d), .o_tx_en(o_tx_en), .o_tx_sof(o_tx_sof),
        .o_tx_eof(o_tx_eof), .o_len_err(o_len_err), .o_grant(o_grant)
    );

    typedef struct {
        logic [N-1:0][11:0] len0;
        logic [N-1:0][11:0] len1;
        logic [5:0][2:0]    order;
        int                 errs;
        int                 bytes;
    } vec_t;

    vec_t        tv[NV];
    int          n_vec = 0;
    int          n_bad = 0;
    int          len_q[N][$];
    int          bptr[N];
    int          mptr[N];
    int          rr_m;
    logic [7:0]  exp_bytes[$];
    int          order_q[$];
    int          err_pending, err_seen, bytes_seen, rd_left, cur_port;
    bit          cur_legal, prev_issue, frame_first, in_tx_frame;
    int          cyc = 0;
    int          last_eof_cyc, low_in_frame;
    int          tx_mode, stall_cnt, frame_issued;
    int          exp_errs_r, exp_bytes_r;

    function automatic logic [7:0] data_of(input int p, input int a);
        return 8'((a * 7 + p * 61 + (a >> 8)) & 255);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            if (len_q[(rr_m + k) % N].size() != 0) return (rr_m + k) % N;
        end
        return -1;
    endfunction

    function automatic bit busy();
        for (int p = 0; p < N; p++) if (len_q[p].size() != 0) return 1'b1;
        return (exp_bytes.size() != 0) || (rd_left > 0);
    endfunction

    task automatic drive_inputs();
        for (int p = 0; p < N; p++) begin
            i_pkt_ready[p]         = (len_q[p].size() != 0);
            i_pkt_len[p*FW +: FW]  = (len_q[p].size() != 0) ? FW'(len_q[p][0]) : '0;
            i_rd_data[p*DW +: DW]  = data_of(p, bptr[p]);
        end
        case (tx_mode)
            1: i_tx_ready = ($urandom_range(3) != 0);
            2: begin
                if (frame_issued == 10 && stall_cnt < 5) begin
                    i_tx_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    i_tx_ready = 1'b1;
                end
            end
            default: i_tx_ready = 1'b1;
        endcase
    endtask

    // One clock: compare at the falling edge, then update the buffer model after the rising edge.
    task automatic step();
        logic [N-1:0] rd_s, pop_s;
        logic [7:0]   b;
        int           exp_p, pop_port, tmp;
        @(negedge iclk);
        cyc++;
        rd_s  = o_rd_en;
        pop_s = o_len_pop;
        pop_port = -1;

        chk("len_err", o_len_err, err_pending);
        err_pending = 0;
        if (o_len_err) err_seen++;

        chk("tx_latency", o_tx_en, prev_issue);
        if (o_tx_en) begin
            if (exp_bytes.size() == 0) begin
                chk("tx_unexpected", 1, 0);
            end else begin
                b = exp_bytes.pop_front();
                chk("tx_data", o_tx_d, b);
                chk("tx_sof", o_tx_sof, frame_first);
                chk("tx_eof", o_tx_eof, exp_bytes.size() == 0);
                if (frame_first && last_eof_cyc >= 0) chk("ifg", (cyc - last_eof_cyc - 1) >= IFG, 1);
                if (frame_first) in_tx_frame = 1'b1;
                frame_first = 1'b0;
                bytes_seen++;
                if (exp_bytes.size() == 0) begin
                    last_eof_cyc = cyc;
                    in_tx_frame  = 1'b0;
                end
            end
        end else begin
            chk("tx_flags_idle", {o_tx_sof, o_tx_eof}, 0);
            if (in_tx_frame) low_in_frame++;
        end

        if (rd_s != 0) begin
            chk("rd_en_port", rd_s, N'(1) << cur_port);
            chk("grant_hold", o_grant, cur_port);
            if (rd_left <= 0) chk("rd_en_extra", 1, 0);
            else rd_left--;
            if (cur_legal) begin
                chk("rd_en_ready", i_tx_ready, 1);
                frame_issued++;
            end
        end
        prev_issue = (rd_s != 0) && cur_legal;

        if (pop_s != 0) begin
            exp_p = model_pick();
            if (exp_p < 0) begin
                chk("pop_unexpected", 1, 0);
            end else begin
                chk("pop_port", pop_s, N'(1) << exp_p);
                chk("grant", o_grant, exp_p);
                chk("pop_while_busy", rd_left, 0);
                pop_port  = exp_p;
                cur_port  = exp_p;
                rr_m      = (exp_p + 1) % N;
                order_q.push_back(exp_p);
                rd_left   = len_q[exp_p][0];
                cur_legal = (rd_left >= MINL) && (rd_left <= MAXL);
                err_pending = cur_legal ? 0 : 1;
                if (cur_legal) begin
                    for (int k = 0; k < rd_left; k++) exp_bytes.push_back(data_of(exp_p, mptr[exp_p] + k));
                end
                mptr[exp_p] += rd_left;
                frame_first  = 1'b1;
                frame_issued = 0;
                stall_cnt    = 0;
            end
        end

        @(posedge iclk);
        #1;
        for (int p = 0; p < N; p++) if (rd_s[p]) bptr[p]++;
        if (pop_port >= 0) tmp = len_q[pop_port].pop_front();
        drive_inputs();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        @(posedge iclk);
        #1;
        chk("rst_len_pop", o_len_pop, 0);
        chk("rst_rd_en", o_rd_en, 0);
        chk("rst_tx_d", o_tx_d, 0);
        chk("rst_tx_en", o_tx_en, 0);
        chk("rst_sof", o_tx_sof, 0);
        chk("rst_eof", o_tx_eof, 0);
        chk("rst_len_err", o_len_err, 0);
        chk("rst_grant", o_grant, 0);
        for (int p = 0; p < N; p++) begin
            len_q[p].delete();
            bptr[p] = 0;
            mptr[p] = 0;
        end
        exp_bytes.delete();
        order_q.delete();
        rr_m = 0; err_pending = 0; err_seen = 0; bytes_seen = 0; rd_left = 0; cur_port = 0;
        cur_legal = 0; prev_issue = 0; frame_first = 0; in_tx_frame = 0;
        last_eof_cyc = -1; low_in_frame = 0; stall_cnt = 0; frame_issued = 0;
        i_rst = 1'b0;
        drive_inputs();
    endtask

    task automatic run_until_done(input int budget);
        int k = 0;
        while (busy() && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: still busy after %0d cycles, required idle", k);
        end
        repeat (IFG + 4) step();
    endtask

    task automatic check_align();
        for (int p = 0; p < N; p++) chk("ptr_align", bptr[p], mptr[p]);
    endtask

    initial begin
        int cnt, k, L;
        i_rst = 1'b1; i_pkt_ready = '0; i_pkt_len = '0; i_rd_data = '0; i_tx_ready = 1'b0;
        tx_mode = 0;

        for (int i = 0; i < NV; i++) begin
            for (int p = 0; p < N; p++) begin
                tv[i].len0[p] = NONE;
                tv[i].len1[p] = NONE;
            end
            for (int j = 0; j < 6; j++) tv[i].order[j] = 3'd7;
        end
        // single port, minimum length
        tv[0].len0[1] = 12'd64;
        tv[0].order[0] = 3'd1; tv[0].errs = 0; tv[0].bytes = 64;
        // all ports, port 0 has a second packet that must wait for 1..3
        for (int p = 0; p < N; p++) tv[1].len0[p] = 12'd64;
        tv[1].len1[0] = 12'd64;
        tv[1].order[0] = 3'd0; tv[1].order[1] = 3'd1; tv[1].order[2] = 3'd2;
        tv[1].order[3] = 3'd3; tv[1].order[4] = 3'd0; tv[1].errs = 0; tv[1].bytes = 320;
        // short frame drained, neighbour served
        tv[2].len0[2] = 12'd20; tv[2].len0[3] = 12'd64;
        tv[2].order[0] = 3'd2; tv[2].order[1] = 3'd3; tv[2].errs = 1; tv[2].bytes = 64;
        // zero length
        tv[3].len0[0] = 12'd0; tv[3].len0[1] = 12'd70;
        tv[3].order[0] = 3'd0; tv[3].order[1] = 3'd1; tv[3].errs = 1; tv[3].bytes = 70;
        // maximum length
        tv[4].len0[3] = 12'd1536;
        tv[4].order[0] = 3'd3; tv[4].errs = 0; tv[4].bytes = 1536;
        // oversize drain, pointer alignment across frames of the same port
        tv[5].len0[0] = 12'd65; tv[5].len1[0] = 12'd2000; tv[5].len0[2] = 12'd64;
        tv[5].order[0] = 3'd0; tv[5].order[1] = 3'd2; tv[5].order[2] = 3'd0;
        tv[5].errs = 1; tv[5].bytes = 129;
        // boundary illegal lengths 1, 63, 1537
        tv[6].len0[0] = 12'd1; tv[6].len0[1] = 12'd63; tv[6].len0[2] = 12'd1537; tv[6].len0[3] = 12'd64;
        tv[6].order[0] = 3'd0; tv[6].order[1] = 3'd1; tv[6].order[2] = 3'd2; tv[6].order[3] = 3'd3;
        tv[6].errs = 3; tv[6].bytes = 64;

        repeat (2) @(posedge iclk);
        #1;

        for (int i = 0; i < NV; i++) begin
            tx_mode = 0;
            do_reset();
            for (int p = 0; p < N; p++) begin
                if (tv[i].len0[p] != NONE) len_q[p].push_back(int'(tv[i].len0[p]));
                if (tv[i].len1[p] != NONE) len_q[p].push_back(int'(tv[i].len1[p]));
            end
            drive_inputs();
            run_until_done(6000);
            cnt = 0;
            for (int j = 0; j < 6; j++) begin
                if (tv[i].order[j] != 3'd7) begin
                    chk("order", (order_q.size() > j) ? order_q[j] : -1, tv[i].order[j]);
                    cnt++;
                end
            end
            chk("order_len", order_q.size(), cnt);
            chk("err_count", err_seen, tv[i].errs);
            chk("byte_count", bytes_seen, tv[i].bytes);
            check_align();
        end

        // len=100 with a five-cycle downstream stall after byte 10
        tx_mode = 2;
        do_reset();
        len_q[0].push_back(100);
        drive_inputs();
        run_until_done(2000);
        chk("stall_bytes", bytes_seen, 100);
        chk("stall_gaps", low_in_frame, 5);
        check_align();

        // randomized traffic with random downstream backpressure
        for (int r = 0; r < 2; r++) begin
            tx_mode = 1;
            do_reset();
            exp_errs_r = 0; exp_bytes_r = 0;
            for (int p = 0; p < N; p++) begin
                cnt = $urandom_range(3);
                for (int j = 0; j < cnt; j++) begin
                    case ($urandom_range(9))
                        0: L = 0;
                        1: L = 1 + $urandom_range(62);
                        2: L = 1537 + $urandom_range(300);
                        default: L = MINL + $urandom_range(40);
                    endcase
                    len_q[p].push_back(L);
                    if (L >= MINL && L <= MAXL) exp_bytes_r += L;
                    else exp_errs_r++;
                end
            end
            drive_inputs();
            run_until_done(20000);
            chk("rand_bytes", bytes_seen, exp_bytes_r);
            chk("rand_errs", err_seen, exp_errs_r);
            check_align();
        end

        // reset in the middle of a frame, then round-robin restarts at port 0
        tx_mode = 0;
        do_reset();
        len_q[1].push_back(100);
        drive_inputs();
        k = 0;
        while (bytes_seen < 30 && k < 500) begin
            step();
            k++;
        end
        chk("midrst_reached", bytes_seen, 30);
        do_reset();
        repeat (4) step();
        len_q[0].push_back(64);
        len_q[3].push_back(64);
        drive_inputs();
        run_until_done(2000);
        chk("midrst_first", (order_q.size() > 0) ? order_q[0] : -1, 0);
        chk("midrst_bytes", bytes_seen, 128);
        check_align();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
